// File: rtl/bcd_calc_pkg.sv
// Shared definitions for the BCD calculator controller: key codes and the
// entry FSM state type.
package bcd_calc_pkg;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_EQ    = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;

    typedef enum logic [1:0] {
        ENT_A = 2'd0,
        ENT_B = 2'd1,
        SHOW  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_key_decode.sv
// Combinational key classifier. Every flag is qualified by key_valid_i, so
// all flags are low when no key is being presented.
//   key_i        : 4-bit key code
//   key_valid_i  : key strobe
//   is_digit_o   : code 0..9
//   is_op_o      : PLUS or MINUS
//   op_is_sub_o  : the operator key is MINUS
//   is_eq_o      : EQ
//   is_clr_o     : CLR
//   is_bad_o     : unassigned codes 14..15
module bcd_key_decode
    import bcd_calc_pkg::*;
(
    input  logic [3:0] key_i,
    input  logic       key_valid_i,
    output logic       is_digit_o,
    output logic       is_op_o,
    output logic       op_is_sub_o,
    output logic       is_eq_o,
    output logic       is_clr_o,
    output logic       is_bad_o
);

    always_comb begin
        is_digit_o  = key_valid_i && (key_i <= 4'd9);
        is_op_o     = key_valid_i && ((key_i == KEY_PLUS) || (key_i == KEY_MINUS));
        op_is_sub_o = key_valid_i && (key_i == KEY_MINUS);
        is_eq_o     = key_valid_i && (key_i == KEY_EQ);
        is_clr_o    = key_valid_i && (key_i == KEY_CLR);
        is_bad_o    = key_valid_i && (key_i > KEY_CLR);
    end

endmodule

// File: rtl/bcd_calc_ctrl.sv
// Key-entry controller for a 2-digit BCD calculator. Collects operands,
// drives an external combinational add/sub stage and commits its result.
//   clk, rst   : clock, asynchronous active-high reset
//   key        : key code, sampled when key_valid is high
//   key_valid  : single-cycle key strobe
//   op_res     : BCD result returned by the external add/sub stage
//   op_a, op_b : registered BCD operands to the add/sub stage
//   op_sub     : registered operation select (1 = A-B)
//   disp       : registered display value (op_b in ENT_B, else op_a)
//   res_valid  : one-cycle pulse when a result is committed
//   key_err    : one-cycle pulse when a key is rejected
module bcd_calc_ctrl
    import bcd_calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic [7:0] op_res,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       op_sub,
    output logic [7:0] disp,
    output logic       res_valid,
    output logic       key_err
);

    logic is_digit, is_op, op_is_sub, is_eq, is_clr, is_bad;

    bcd_key_decode u_dec (
        .key_i       (key),
        .key_valid_i (key_valid),
        .is_digit_o  (is_digit),
        .is_op_o     (is_op),
        .op_is_sub_o (op_is_sub),
        .is_eq_o     (is_eq),
        .is_clr_o    (is_clr),
        .is_bad_o    (is_bad)
    );

    state_t     state_q, state_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic       op_sub_q, op_sub_d;
    logic [7:0] disp_q, disp_d;
    logic       res_valid_q, res_valid_d;
    logic       key_err_q, key_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENT_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sub_q    <= 1'b0;
            disp_q      <= '0;
            res_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sub_q    <= op_sub_d;
            disp_q      <= disp_d;
            res_valid_q <= res_valid_d;
            key_err_q   <= key_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sub_d    = op_sub_q;
        res_valid_d = 1'b0;
        key_err_d   = 1'b0;

        if (is_clr) begin
            state_d  = ENT_A;
            op_a_d   = '0;
            op_b_d   = '0;
            op_sub_d = 1'b0;
        end else if (is_bad) begin
            key_err_d = 1'b1;
        end else begin
            unique case (state_q)
                ENT_A: begin
                    if (is_digit) begin
                        op_a_d = {op_a_q[3:0], key};
                    end else if (is_op) begin
                        op_sub_d = op_is_sub;
                        op_b_d   = '0;
                        state_d  = ENT_B;
                    end else if (is_eq) begin
                        key_err_d = 1'b1;
                    end
                end
                ENT_B: begin
                    if (is_digit) begin
                        op_b_d = {op_b_q[3:0], key};
                    end else if (is_op) begin
                        // Chaining: commit the pending result as the new A.
                        op_a_d      = op_res;
                        op_sub_d    = op_is_sub;
                        op_b_d      = '0;
                        res_valid_d = 1'b1;
                    end else if (is_eq) begin
                        op_a_d      = op_res;
                        res_valid_d = 1'b1;
                        state_d     = SHOW;
                    end
                end
                SHOW: begin
                    if (is_digit) begin
                        op_a_d  = {4'h0, key};
                        state_d = ENT_A;
                    end else if (is_op) begin
                        op_sub_d = op_is_sub;
                        op_b_d   = '0;
                        state_d  = ENT_B;
                    end else if (is_eq) begin
                        // Repeat last operation with the kept B and op.
                        op_a_d      = op_res;
                        res_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ENT_A;
                end
            endcase
        end

        // Display follows the operand that the next state is editing.
        disp_d = (state_d == ENT_B) ? op_b_d : op_a_d;
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_sub    = op_sub_q;
    assign disp      = disp_q;
    assign res_valid = res_valid_q;
    assign key_err   = key_err_q;

endmodule

// File: tb/tb_bcd_calc_ctrl.sv
module tb_bcd_calc_ctrl;
    import bcd_calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = '0;
    logic       key_valid = 1'b0;
    logic [7:0] op_res;
    logic [7:0] op_a, op_b, disp;
    logic       op_sub, res_valid, key_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // External add/sub stage (modulo-100 BCD, 10's complement subtraction).
    assign op_res = op_sub ? to_bcd((from_bcd(op_a) - from_bcd(op_b) + 100) % 100)
                           : to_bcd((from_bcd(op_a) + from_bcd(op_b)) % 100);

    bcd_calc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .key_valid (key_valid),
        .op_res    (op_res),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .disp      (disp),
        .res_valid (res_valid),
        .key_err   (key_err)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    typedef struct {
        logic [7:0] disp;
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       rv;
        logic       ke;
    } exp_t;

    exp_t sb[$];

    // Reference model: calculator behaviour in plain decimal integers.
    int m_st  = 0;   // 0 = entering A, 1 = entering B, 2 = showing result
    int m_a   = 0;
    int m_b   = 0;
    int m_sub = 0;

    task automatic model_reset();
        m_st = 0; m_a = 0; m_b = 0; m_sub = 0;
    endtask

    task automatic send_key(input int k);
        exp_t e;
        int r;
        @(negedge clk);
        key       = 4'(k);
        key_valid = 1'b1;
        r  = (m_sub != 0) ? (m_a - m_b + 100) % 100 : (m_a + m_b) % 100;
        e.rv = 1'b0;
        e.ke = 1'b0;
        if (k == 13) begin
            model_reset();
        end else if (k >= 14) begin
            e.ke = 1'b1;
        end else if (m_st == 0) begin
            if (k <= 9)       m_a = (m_a % 10) * 10 + k;
            else if (k <= 11) begin m_sub = (k == 11); m_b = 0; m_st = 1; end
            else              e.ke = 1'b1;
        end else if (m_st == 1) begin
            if (k <= 9)       m_b = (m_b % 10) * 10 + k;
            else if (k <= 11) begin m_a = r; m_sub = (k == 11); m_b = 0; e.rv = 1'b1; end
            else              begin m_a = r; e.rv = 1'b1; m_st = 2; end
        end else begin
            if (k <= 9)       begin m_a = k; m_st = 0; end
            else if (k <= 11) begin m_sub = (k == 11); m_b = 0; m_st = 1; end
            else              begin m_a = r; e.rv = 1'b1; end
        end
        e.a    = to_bcd(m_a);
        e.b    = to_bcd(m_b);
        e.sub  = (m_sub != 0);
        e.disp = (m_st == 1) ? e.b : e.a;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            key_valid = 1'b0;
        end
    endtask

    task automatic send_seq(input int ks[$]);
        foreach (ks[i]) send_key(ks[i]);
        idle(2);
    endtask

    // Monitor: a key accepted on an edge must produce the next queued
    // response; idle edges must hold everything and pulse nothing.
    logic [7:0] last_disp = '0, last_a = '0, last_b = '0;
    logic       last_sub = 1'b0;

    always @(posedge clk) begin
        logic took, in_rst;
        exp_t e;
        took   = key_valid && !rst;
        in_rst = rst;
        #1;
        if (in_rst) begin
            last_disp = '0; last_a = '0; last_b = '0; last_sub = 1'b0;
        end else if (took) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("disp", disp, e.disp);
                chk("op_a", op_a, e.a);
                chk("op_b", op_b, e.b);
                chk("op_sub", op_sub, e.sub);
                chk("res_valid", res_valid, e.rv);
                chk("key_err", key_err, e.ke);
                last_disp = e.disp; last_a = e.a; last_b = e.b; last_sub = e.sub;
            end
        end else begin
            chk("idle_res_valid", res_valid, 0);
            chk("idle_key_err", key_err, 0);
            chk("idle_disp", disp, last_disp);
            chk("idle_op_a", op_a, last_a);
            chk("idle_op_b", op_b, last_b);
            chk("idle_op_sub", op_sub, last_sub);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_op_a"}, op_a, 0);
        chk({tag, "_op_b"}, op_b, 0);
        chk({tag, "_op_sub"}, op_sub, 0);
        chk({tag, "_disp"}, disp, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_key_err"}, key_err, 0);
    endtask

    initial begin
        int k, r;
        #3;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 12 + 34
        send_seq('{1, 2, 10, 3, 4, 12});
        chk("add_disp", disp, 8'h46);
        chk("add_op_b", op_b, 8'h34);

        // 3 - 5 then repeated EQ
        send_seq('{13, 0, 3, 11, 0, 5, 12});
        chk("sub_disp", disp, 8'h98);
        send_seq('{12});
        chk("sub_rep1", disp, 8'h93);
        send_seq('{12});
        chk("sub_rep2", disp, 8'h88);

        // 99 + 01 chained + 02
        send_seq('{13, 9, 9, 10, 0, 1, 10});
        chk("chain_disp", disp, 8'h00);
        send_seq('{0, 2, 12});
        chk("chain_eq", disp, 8'h02);

        // Digit overflow and rejected keys
        send_seq('{13, 1, 2, 3});
        chk("shift_op_a", op_a, 8'h23);
        send_seq('{12, 14});
        chk("err_op_a", op_a, 8'h23);

        // Asynchronous reset mid-entry, key during reset ignored
        send_seq('{13, 4, 5, 10, 6});
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        key = 4'd7; key_valid = 1'b1;
        @(negedge clk);
        chk_zero("rst_key_ignored");
        key_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        send_seq('{7});
        chk("post_rst", disp, 8'h07);

        // SHOW then digit; CLR in ENT_B
        send_seq('{13, 1, 2, 10, 3, 4, 12, 5});
        chk("show_digit", disp, 8'h05);
        send_seq('{11, 8, 13});
        chk("clr_op_a", op_a, 0);
        chk("clr_op_b", op_b, 0);
        chk("clr_op_sub", op_sub, 0);

        // Random key stream with back-to-back keys and idle gaps
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      k = $urandom_range(0, 9);
            else if (r < 65) k = 10;
            else if (r < 73) k = 11;
            else if (r < 85) k = 12;
            else if (r < 90) k = 13;
            else             k = $urandom_range(14, 15);
            send_key(k);
            if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
        end
        idle(3);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
